// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffer: FSM encoding, exception code,
// default redirect PCs and the packed entry width helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [4:0]  EXC_NONE     = 5'd0;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

  // Entry layout, MSB first: pc(32) instr(32) data(NLANE*DW) addr(NADDR*AW) exc(5) bd(1)
  function automatic int entry_width(input int nlane, input int dw,
                                     input int naddr, input int aw);
    return 64 + nlane * dw + naddr * aw + 6;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One packed pipeline entry register; load copies a new entry, bubble keeps only
// the supplied pc/bd and zeroes instr/data/addr/exc.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int          W      = 166,
  parameter logic [31:0] RST_PC = DEF_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         bubble,
  input  logic [31:0]  bubble_pc,
  input  logic         bubble_bd,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= {RST_PC, {(W-38){1'b0}}, EXC_NONE, 1'b0};
    end else if (bubble) begin
      q_reg <= {bubble_pc, {(W-38){1'b0}}, EXC_NONE, bubble_bd};
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid, bubble (clr) and
// exception redirect (req). Optional counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          NLANE    = 3,
  parameter int          AW       = 5,
  parameter int          NADDR    = 3,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_instr,
  input  logic [NLANE*DW-1:0]   in_data,
  input  logic [NADDR*AW-1:0]   in_addr,
  input  logic [4:0]            in_exc,
  input  logic                  in_bd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic [NLANE*DW-1:0]   out_data,
  output logic [NADDR*AW-1:0]   out_addr,
  output logic [4:0]            out_exc,
  output logic                  out_bd,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt,
`endif
  output logic [1:0]            occ
);

  localparam int EW        = entry_width(NLANE, DW, NADDR, AW);
  localparam int ADDR_LSB  = 6;
  localparam int DATA_LSB  = ADDR_LSB + NADDR * AW;
  localparam int INSTR_LSB = DATA_LSB + NLANE * DW;

  state_t        state_reg, state_next;
  logic          accept, pop;
  logic          head_load, head_from_skid, head_bubble, skid_load;
  logic [31:0]   bubble_pc;
  logic          bubble_bd;
  logic [EW-1:0] in_entry, head_d, head_q, skid_q;

  assign in_entry = {in_pc, in_instr, in_data, in_addr, in_exc, in_bd};
  assign in_ready = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign occ      = state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_bubble    = 1'b0;
    skid_load      = 1'b0;
    bubble_pc      = in_pc;
    bubble_bd      = in_bd;
    if (req) begin
      state_next  = ST_EMPTY;
      head_bubble = 1'b1;
      bubble_pc   = EXC_PC;
      bubble_bd   = 1'b0;
    end else if (clr) begin
      // A pop in this cycle has already been seen downstream; just drop everything.
      state_next  = ST_EMPTY;
      head_bubble = 1'b1;
    end else begin
      unique case (state_reg)
        ST_EMPTY: if (accept) begin
          head_load  = 1'b1;
          state_next = ST_ONE;
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end else if (pop) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          state_next     = ST_ONE;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : in_entry;

  pipe_entry_reg #(.W(EW), .RST_PC(RESET_PC)) u_head (
    .clk(clk), .reset(reset), .load(head_load), .d(head_d),
    .bubble(head_bubble), .bubble_pc(bubble_pc), .bubble_bd(bubble_bd), .q(head_q)
  );

  pipe_entry_reg #(.W(EW), .RST_PC(32'd0)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .d(in_entry),
    .bubble(req | clr), .bubble_pc(32'd0), .bubble_bd(1'b0), .q(skid_q)
  );

  // The head register may still hold a popped entry; only pc/bd stay visible when empty.
  assign out_pc    = head_q[EW-1 -: 32];
  assign out_bd    = head_q[0];
  assign out_instr = out_valid ? head_q[INSTR_LSB +: 32] : 32'd0;
  assign out_exc   = out_valid ? head_q[1 +: 5] : EXC_NONE;

  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      assign out_data[gi*DW +: DW] = out_valid ? head_q[DATA_LSB + gi*DW +: DW] : {DW{1'b0}};
    end
    for (gi = 0; gi < NADDR; gi++) begin : g_addr
      assign out_addr[gi*AW +: AW] = out_valid ? head_q[ADDR_LSB + gi*AW +: AW] : {AW{1'b0}};
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_reg, bubble_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= 32'd0;
      bubble_cnt_reg <= 32'd0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (clr && !req)             bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 32, NLANE = 3, AW = 5, NADDR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b0, clr = 1'b0, req = 1'b0;
  logic                in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, in_bd = 1'b0, out_bd;
  logic [31:0]         in_pc = '0, in_instr = '0, out_pc, out_instr;
  logic [NLANE*DW-1:0] in_data = '0, out_data;
  logic [NADDR*AW-1:0] in_addr = '0, out_addr;
  logic [4:0]          in_exc = '0, out_exc;
  logic [1:0]          occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]         stall_cnt, bubble_cnt;
`endif

  pipe_stage_buf dut (
    .clk(clk), .reset(reset), .clr(clr), .req(req),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data), .in_addr(in_addr), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_data(out_data), .out_addr(out_addr), .out_exc(out_exc), .out_bd(out_bd),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .occ(occ)
  );

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [NLANE*DW-1:0] data;
    logic [NADDR*AW-1:0] addr;
    logic [4:0]          exc;
    logic                bd;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = 32'h3000;
  logic        m_bd = 1'b0;
  bit          m_pc_known = 1'b1;
  int unsigned m_stall = 0, m_bubble = 0;
  bit          cmp_en = 1'b0;
  int          tot = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries plus the pc/bd shown while empty.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_pc = 32'h3000; m_bd = 1'b0; m_pc_known = 1'b1;
      m_stall = 0; m_bubble = 0;
    end else begin
      bit acc, pop;
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready) m_stall++;
      if (clr && !req) m_bubble++;
      if (pop) $display("xfer pc=%h instr=%h exc=%0d bd=%0b", q[0].pc, q[0].instr, q[0].exc, q[0].bd);
      if (req) begin
        q.delete(); m_pc = 32'h4180; m_bd = 1'b0; m_pc_known = 1'b1;
      end else if (clr) begin
        q.delete(); m_pc = in_pc; m_bd = in_bd; m_pc_known = 1'b1;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          if (q.size() == 0) m_pc_known = 1'b0;
        end
        if (acc) q.push_back({in_pc, in_instr, in_data, in_addr, in_exc, in_bd});
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("occ", occ, q.size());
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
        chk("out_data", out_data, q[0].data);
        chk("out_addr", out_addr, q[0].addr);
        chk("out_exc", out_exc, q[0].exc);
        chk("out_bd", out_bd, q[0].bd);
      end else begin
        chk("idle_payload", {out_instr, out_data, out_addr, out_exc}, '0);
        if (m_pc_known) begin
          chk("idle_pc", out_pc, m_pc);
          chk("idle_bd", out_bd, m_bd);
        end
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = $urandom;
    in_data  = {$urandom, $urandom, $urandom};
    in_addr  = 15'($urandom);
    in_exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
    in_bd    = 1'($urandom);
    clr      = 1'b0;
    req      = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] snap;
    cmp_en = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    chk("rst_pc", out_pc, 32'h3000);
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    // Streaming with out_ready high: one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i));
      step();
      chk("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
      chk("stream_occ", occ, 2'd1);
    end

    // Stall: fills skid, then blocks.
    out_ready = 1'b0;
    drive(1'b1, 32'h300C); step();
    chk("stall_occ2", occ, 2'd2);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_head_pc", out_pc, 32'h3008);
    drive(1'b1, 32'h3010); step();
    chk("stall_hold_occ", occ, 2'd2);
    out_ready = 1'b1;
    drive(1'b0, 32'h0); step();
    chk("drain_pc", out_pc, 32'h300C);
    chk("drain_occ", occ, 2'd1);
    step();
    chk("drain_empty", out_valid, 1'b0);

    // clr at occ=2 leaves a bubble carrying in_pc / in_bd.
    out_ready = 1'b0;
    drive(1'b1, 32'h3020); step();
    drive(1'b1, 32'h3024); step();
    chk("clr_pre_occ", occ, 2'd2);
    drive(1'b0, 32'h3010); in_bd = 1'b1; clr = 1'b1; step();
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_pc", out_pc, 32'h3010);
    chk("clr_bd", out_bd, 1'b1);
    chk("clr_instr", out_instr, 32'd0);
    chk("clr_occ", occ, 2'd0);

    // req wins over clr.
    drive(1'b1, 32'h3030); step();
    drive(1'b1, 32'h3034); step();
`ifdef PIPE_STAGE_PERF_EN
    snap = bubble_cnt;
`else
    snap = 32'd0;
`endif
    drive(1'b0, 32'h3040); in_bd = 1'b1; clr = 1'b1; req = 1'b1; step();
    chk("req_pc", out_pc, 32'h4180);
    chk("req_bd", out_bd, 1'b0);
    chk("req_exc", out_exc, 5'd0);
    chk("req_occ", occ, 2'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("req_bubble_hold", bubble_cnt - snap, 32'd0);
    drive(1'b1, 32'h3050); step();
    snap = stall_cnt;
    drive(1'b0, 32'h0);
    repeat (4) step();
    chk("perf_stall4", stall_cnt - snap, 32'd4);
    snap = bubble_cnt;
    drive(1'b0, 32'h3060); clr = 1'b1;
    repeat (2) step();
    chk("perf_bubble2", bubble_cnt - snap, 32'd2);
`endif

    // Asynchronous reset mid-cycle with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 32'h3070); step();
    drive(1'b1, 32'h3074); step();
    chk("arst_pre_occ", occ, 2'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", out_pc, 32'h3000);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_occ", occ, 2'd0);
    step();
    reset = 1'b1;
    drive(1'b0, 32'h0);
    step();
    chk("arst_in_ready", in_ready, 1'b1);

    // Randomized traffic.
    repeat (3000) begin
      drive($urandom_range(0, 3) != 0, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      req = ($urandom_range(0, 39) == 0);
      step();
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
